vertex_project_seq: RTL and testbench

- Sequential, parametrised successor to the combinational triangle projection path.
- Accepts one triangle (three xyz vertices, signed WI.WF fixed point) with a 4x4 MVP matrix and a viewport size, over a valid/ready handshake.
- Computes clip-space x/y/w with a single shared multiply-accumulator, then the perspective divide with a serial restoring divider, then the viewport map.
- Emits integer screen coordinates plus a per-vertex clip flag to the rasteriser over a valid/ready handshake.

---
 rtl/vertex_project_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_vertex_project_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_project_seq.sv
// Triangle projection: shared-MAC MVP transform, serial restoring divide,
// then viewport map; one triangle in flight over valid/ready handshakes.
module vertex_project_seq #(
   parameter int WI = 8,
   parameter int WF = 8,
   parameter int SW = 10
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0][2:0][WI+WF-1:0]  orig_triangle,
   input  logic [15:0][WI+WF-1:0]      mvp,
   input  logic [SW-1:0]               width,
   input  logic [SW-1:0]               height,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2:0][1:0][SW-1:0]     proj_triangle,
   output logic [2:0]                  clip
);
   localparam int N  = WI + WF;
   localparam int DW = WI + 2 * WF;
   localparam int AW = 2 * N + 2;
   localparam int SH = AW - WF;
   localparam int NW = WF + 2;
   localparam int PW = NW + SW;
   localparam int CW = ($clog2(DW) > 4) ? $clog2(DW) : 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MAC   = 3'd1;
   localparam logic [2:0] S_DIVX  = 3'd2;
   localparam logic [2:0] S_DIVY  = 3'd3;
   localparam logic [2:0] S_VPORT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]                 state_q;
   logic [CW-1:0]              cnt_q;
   logic [1:0]                 vtx_q;
   logic [2:0][2:0][N-1:0]     tri_q;
   logic [11:0][N-1:0]         mvp_q;
   logic [SW-1:0]              width_q;
   logic [SW-1:0]              height_q;
   logic signed [AW-1:0]       acc_q;
   logic signed [N-1:0]        xc_q;
   logic signed [N-1:0]        yc_q;
   logic signed [N-1:0]        wc_q;
   logic [N-1:0]               rem_q;
   logic [DW-1:0]              quo_q;
   logic signed [NW-1:0]       ndcx_q;
   logic signed [NW-1:0]       ndcy_q;
   logic [2:0][1:0][SW-1:0]    proj_q;
   logic [2:0]                 clip_q;
   logic                       out_valid_q;

   // Matrix row 2 (z) never contributes to x, y or w.
   logic unused_row2;
   assign unused_row2 = ^mvp[11:8];

   function automatic logic [N-1:0] mag_f(input logic signed [N-1:0] v);
      return v[N-1] ? -v : v;
   endfunction

   function automatic logic signed [NW-1:0] ndc_f(
      input logic [DW-1:0] q,
      input logic          neg,
      input logic          ok
   );
      logic [NW-1:0] mag;
      mag = (q > DW'(1 << WF)) ? NW'(1 << WF) : q[NW-1:0];
      if (!ok) return '0;
      return neg ? -mag : mag;
   endfunction

   function automatic logic [SW-1:0] vp_f(
      input logic signed [NW-1:0] ndc,
      input logic [SW-1:0]        dim
   );
      logic [NW-1:0] off;
      logic [PW-1:0] p;
      logic [SW:0]   s;
      off = ndc + NW'(1 << WF);
      p   = {{SW{1'b0}}, off} * {{NW{1'b0}}, dim};
      s   = (SW+1)'(p >> (WF + 1));
      if (dim == '0) return '0;
      if (s >= {1'b0, dim}) return dim - 1'b1;
      return s[SW-1:0];
   endfunction

   logic [1:0]            col;
   logic signed [N-1:0]   opa;
   logic signed [N-1:0]   opb;
   logic signed [2*N-1:0] prod;
   logic signed [AW-1:0]  acc_d;
   logic signed [SH-1:0]  accs;
   logic signed [N-1:0]   sat;

   always_comb begin
      col   = cnt_q[1:0];
      opa   = mvp_q[cnt_q[3:0]];
      opb   = (col == 2'd3) ? N'(1 << WF) : tri_q[vtx_q][col];
      prod  = {{N{opa[N-1]}}, opa} * {{N{opb[N-1]}}, opb};
      acc_d = ((col == 2'd0) ? '0 : acc_q)
            + {{2{prod[2*N-1]}}, prod};
      accs  = acc_d[AW-1:WF];
      if ((&accs[SH-1:N-1]) || !(|accs[SH-1:N-1]))
         sat = accs[N-1:0];
      else
         sat = {accs[SH-1], {(N-1){~accs[SH-1]}}};
   end

   logic [N-1:0]  dvs;
   logic [N:0]    trial;
   logic [N-1:0]  diff;
   logic          ge;
   logic [N-1:0]  rem_d;
   logic [DW-1:0] quo_d;
   logic          wpos;

   always_comb begin
      dvs   = mag_f(wc_q);
      wpos  = !wc_q[N-1] && (wc_q != '0);
      trial = {rem_q, quo_q[DW-1]};
      diff  = trial[N-1:0] - dvs;
      ge    = trial >= {1'b0, dvs};
      rem_d = ge ? diff : trial[N-1:0];
      quo_d = {quo_q[DW-2:0], ge};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         vtx_q       <= '0;
         tri_q       <= '0;
         mvp_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         acc_q       <= '0;
         xc_q        <= '0;
         yc_q        <= '0;
         wc_q        <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         ndcx_q      <= '0;
         ndcy_q      <= '0;
         proj_q      <= '0;
         clip_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  tri_q    <= orig_triangle;
                  mvp_q    <= {mvp[15:12], mvp[7:0]};
                  width_q  <= width;
                  height_q <= height;
                  vtx_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= S_MAC;
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (col == 2'd3) begin
                  if (cnt_q[3:2] == 2'd0)      xc_q <= sat;
                  else if (cnt_q[3:2] == 2'd1) yc_q <= sat;
                  else                         wc_q <= sat;
               end
               if (cnt_q == CW'(11)) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= {mag_f(xc_q), {WF{1'b0}}};
                  state_q <= S_DIVX;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DIVX: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(DW - 1)) begin
                  ndcx_q  <= ndc_f(quo_d, xc_q[N-1], wpos);
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= {mag_f(yc_q), {WF{1'b0}}};
                  state_q <= S_DIVY;
               end
            end
            S_DIVY: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(DW - 1)) begin
                  ndcy_q  <= ndc_f(quo_d, yc_q[N-1], wpos);
                  cnt_q   <= '0;
                  state_q <= S_VPORT;
               end
            end
            S_VPORT: begin
               proj_q[vtx_q][0] <= wpos ? vp_f(ndcx_q, width_q) : '0;
               proj_q[vtx_q][1] <= wpos ? vp_f(ndcy_q, height_q) : '0;
               clip_q[vtx_q]    <= !wpos;
               cnt_q            <= '0;
               if (vtx_q == 2'd2) begin
                  state_q <= S_DONE;
               end else begin
                  vtx_q   <= vtx_q + 2'd1;
                  state_q <= S_MAC;
               end
            end
            S_DONE: begin
               // One settle cycle before presenting the result.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = out_valid_q;
   assign proj_triangle = proj_q;
   assign clip          = clip_q;

endmodule

// File: tb/tb_vertex_project_seq.sv
// Bench for vertex_project_seq: table of triangles with hand-derived screen
// coordinates, a result scoreboard, backpressure and mid-flight reset.
`timescale 1ns/1ps
module tb_vertex_project_seq;
   localparam int N   = 16;
   localparam int SW  = 10;
   localparam int LAT = 184;

   typedef logic [2:0][2:0][N-1:0]  tri_t;
   typedef logic [15:0][N-1:0]      mvp_t;
   typedef logic [2:0][1:0][SW-1:0] proj_t;

   typedef struct {
      tri_t          tv;
      mvp_t          m;
      logic [SW-1:0] w;
      logic [SW-1:0] h;
      proj_t         proj;
      logic [2:0]    clip;
   } vec_t;

   typedef struct {
      proj_t      proj;
      logic [2:0] clip;
   } exp_t;

   localparam logic [N-1:0] ONE    = 16'h0100;
   localparam logic [N-1:0] HALF   = 16'h0080;
   localparam logic [N-1:0] NHALF  = 16'hFF80;
   localparam logic [N-1:0] QTR    = 16'h0040;
   localparam logic [N-1:0] NQTR   = 16'hFFC0;
   localparam logic [N-1:0] TQ     = 16'h00C0;
   localparam logic [N-1:0] NEG1   = 16'hFF00;
   localparam logic [N-1:0] TWO    = 16'h0200;
   localparam logic [N-1:0] THREE  = 16'h0300;
   localparam logic [N-1:0] NTHREE = 16'hFD00;
   localparam logic [N-1:0] FOUR   = 16'h0400;

   logic          Clk;
   logic          Reset;
   logic          in_valid;
   logic          in_ready;
   tri_t          orig_triangle;
   mvp_t          mvp;
   logic [SW-1:0] width;
   logic [SW-1:0] height;
   logic          out_valid;
   logic          out_ready;
   proj_t         proj_triangle;
   logic [2:0]    clip;

   vertex_project_seq dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .orig_triangle (orig_triangle),
      .mvp           (mvp),
      .width         (width),
      .height        (height),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .proj_triangle (proj_triangle),
      .clip          (clip)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int   total  = 0;
   int   passed = 0;
   int   acc_cyc;
   exp_t sb[$];
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   function automatic tri_t mk_tri(
      input logic [N-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2);
      tri_t t;
      t[0][0] = x0; t[0][1] = y0; t[0][2] = z0;
      t[1][0] = x1; t[1][1] = y1; t[1][2] = z1;
      t[2][0] = x2; t[2][1] = y2; t[2][2] = z2;
      return t;
   endfunction

   function automatic proj_t mk_proj(
      input int sx0, sy0, sx1, sy1, sx2, sy2);
      proj_t p;
      p[0][0] = SW'(sx0); p[0][1] = SW'(sy0);
      p[1][0] = SW'(sx1); p[1][1] = SW'(sy1);
      p[2][0] = SW'(sx2); p[2][1] = SW'(sy2);
      return p;
   endfunction

   function automatic mvp_t ident();
      mvp_t m;
      m     = '0;
      m[0]  = ONE;
      m[5]  = ONE;
      m[10] = ONE;
      m[15] = ONE;
      return m;
   endfunction

   task automatic apply_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge Clk);
      orig_triangle = v.tv;
      mvp           = v.m;
      width         = v.w;
      height        = v.h;
      in_valid      = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge Clk);
      e.proj = v.proj;
      e.clip = v.clip;
      sb.push_back(e);
      @(negedge Clk);
      acc_cyc       = cyc;
      in_valid      = 1'b0;
      orig_triangle = ~v.tv;
      mvp           = ~v.m;
      width         = ~v.w;
      height        = ~v.h;
   endtask

   task automatic collect(input string tag, input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid && n < 400) begin
         @(negedge Clk);
         n++;
      end
      if (!out_valid) begin
         chk({tag, "_timeout"}, out_valid, 1);
         sb.delete();
         apply_reset();
         return;
      end
      chk({tag, "_latency"}, 64'(cyc - acc_cyc), LAT);
      if (sb.size() == 0) begin
         chk({tag, "_unexpected_out"}, out_valid, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_proj"}, 64'(proj_triangle), 64'(e.proj));
      chk({tag, "_clip"}, clip, e.clip);
      for (int i = 0; i < hold; i++) begin
         in_valid      = i[0];
         orig_triangle = tri_t'(i * 32'h1357);
         @(negedge Clk);
         chk({tag, "_hold_proj"}, 64'(proj_triangle), 64'(e.proj));
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge Clk);
      out_ready = 1'b0;
      chk({tag, "_single_valid"}, out_valid, 0);
      chk({tag, "_in_ready_after"}, in_ready, 1);
   endtask

   initial begin
      vecs[0].m    = ident();
      vecs[0].w    = 100;
      vecs[0].h    = 100;
      vecs[0].tv   = mk_tri(HALF, NHALF, 0, 0, 0, 0, NEG1, ONE, 0);
      vecs[0].proj = mk_proj(75, 25, 50, 50, 0, 99);
      vecs[0].clip = 3'b000;

      vecs[1].m     = '0;
      vecs[1].m[0]  = ONE;
      vecs[1].m[5]  = ONE;
      vecs[1].m[14] = ONE;
      vecs[1].w     = 100;
      vecs[1].h     = 100;
      vecs[1].tv    = mk_tri(ONE, ONE, TWO, 0, 0, NEG1, NEG1, HALF, FOUR);
      vecs[1].proj  = mk_proj(75, 75, 0, 0, 37, 56);
      vecs[1].clip  = 3'b010;

      vecs[2].m    = ident();
      vecs[2].w    = 100;
      vecs[2].h    = 100;
      vecs[2].tv   = mk_tri(THREE, NTHREE, 0, QTR, TQ, 0, 0, 0, 0);
      vecs[2].proj = mk_proj(99, 0, 62, 87, 50, 50);
      vecs[2].clip = 3'b000;

      vecs[3].m    = ident();
      vecs[3].w    = 0;
      vecs[3].h    = 0;
      vecs[3].tv   = mk_tri(HALF, NHALF, 0, ONE, ONE, 0, 0, 0, 0);
      vecs[3].proj = mk_proj(0, 0, 0, 0, 0, 0);
      vecs[3].clip = 3'b000;

      vecs[4].m    = ident();
      vecs[4].w    = 640;
      vecs[4].h    = 480;
      vecs[4].tv   = mk_tri(HALF, HALF, 0, NHALF, NHALF, 0, ONE, ONE, 0);
      vecs[4].proj = mk_proj(480, 360, 160, 120, 639, 479);
      vecs[4].clip = 3'b000;

      vecs[5].m     = '0;
      vecs[5].m[0]  = TWO;
      vecs[5].m[5]  = ONE;
      vecs[5].m[7]  = HALF;
      vecs[5].m[8]  = 16'h7FFF;
      vecs[5].m[15] = ONE;
      vecs[5].w     = 100;
      vecs[5].h     = 100;
      vecs[5].tv    = mk_tri(QTR, 0, 0, 0, 0, 0, NQTR, NHALF, 0);
      vecs[5].proj  = mk_proj(75, 75, 50, 75, 25, 50);
      vecs[5].clip  = 3'b000;

      Clk           = 1'b0;
      Reset         = 1'b1;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      orig_triangle = '0;
      mvp           = '0;
      width         = '0;
      height        = '0;
      repeat (2) @(negedge Clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_proj", 64'(proj_triangle), 0);
      chk("rst_clip", clip, 0);
      Reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         drive(vecs[i]);
         collect($sformatf("vec%0d", i), 0);
      end

      drive(vecs[1]);
      collect("bp", 10);
      repeat (3) @(negedge Clk);
      chk("bp_pulses_ignored", out_valid, 0);

      drive(vecs[2]);
      repeat (50) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_proj", 64'(proj_triangle), 0);
      chk("arst_clip", clip, 0);
      sb.delete();
      @(negedge Clk);
      Reset = 1'b0;
      drive(vecs[0]);
      collect("post_rst", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
